booth_radix4_mac_pipe: RTL and testbench
========================================

// Module: booth_radix4_mac_pipe
// PURPOSE
//  Pipelined, parametrised signed Booth radix-4 multiply-accumulate for systolic PE datapaths.
//  Accepts one operand pair per enabled cycle: operand data_i, weight w_i.
//  Multiplies them with Booth radix-4 partial products and a sign-extension-free adder tree.
//  Either starts a new accumulation or adds to the running sum, with saturation and sticky overflow.
// PARAMETERS
//  DATA_W   8   operand width, signed two's complement; even, >=4
//  ACC_W    24  accumulator/result width, signed; >= 2*DATA_W
//  SAT      1   1: saturate accumulator on overflow; 0: wrap (ovf_o still flags)
// PORTS
//  clk        in   1        clock; all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  en_i       in   1        pipeline advance; 0 = every stage holds (stall)
//  valid_i    in   1        operand pair valid, sampled when en_i=1
//  data_i     in   DATA_W   signed multiplicand
//  w_i        in   DATA_W   signed multiplier (Booth-recoded)
//  acc_i      in   1        1 = add product to accumulator; 0 = load product (start new sum)
//  valid_o    out  1        res_o updated this cycle (one pulse per input transaction)
//  res_o      out  ACC_W    accumulator value, signed
//  ovf_o      out  1        sticky overflow since last load (acc_i=0) transaction
// BEHAVIOUR
//  - Reset: all pipeline registers, valid_o, res_o, ovf_o = 0. Reset mid-operation discards in-flight transactions.
//  - Latency 3 enabled cycles:
//    - S1: Booth-encode DATA_W/2 partial products and register them with pp sign bits, valid and acc.
//    - S2: adder tree, register the 2*DATA_W signed product.
//    - S3: accumulate; result appears on res_o.
//  - Throughput 1/cycle. Stalls count only cycles with en_i=1.
//  - en_i=0: all stages, valid_o, res_o and ovf_o hold. valid_o is not re-pulsed when the stall releases.
//    - Transactions are never dropped or duplicated across a stall.
//  - valid_i=0 with en_i=1: a bubble. acc_i is ignored; accumulator and ovf_o are untouched; valid_o=0 in the matching cycle.
//  - S3, valid transaction, acc_i=0: acc <= sext(product); ovf <= 0.
//  - S3, valid transaction, acc_i=1: sum = acc + sext(product), computed in ACC_W+1 bits.
//    - Overflow when the top two bits of sum differ: ovf <= 1.
//    - SAT=1: acc <= +max or -min by sign of sum. SAT=0: acc <= sum[ACC_W-1:0].
//  - Product arithmetic is exact for all operand pairs, including -2^(DATA_W-1) * -2^(DATA_W-1) = 2^(2*DATA_W-2).
//    - Use sign-extension-prevention constants: inverted extend bit, leading 1s, negate bit injected at the LSB of each pp.
//  - res_o changes only in cycles where valid_o=1; it holds between transactions.
//  - Back-to-back acc_i=1 transactions forward the S3 accumulator combinationally. No bubbles are needed.
// STRUCTURE
//  - Shared package booth_pkg:
//    - Booth digit encoding constants (0, +1, +2, -1, -2) as a typedef.
//    - Function pp_count(DATA_W) = DATA_W/2.
//    - Saturation max/min constant functions of ACC_W.
//  - Sub-module booth_radix4_pp_enc #(DATA_W):
//    - Inputs: one 3-bit multiplier window and data_i.
//    - Outputs: DATA_W+1-bit partial product, extend bit, negate bit.
//    - Instantiated DATA_W/2 times via generate.
//  - Top: generate loop of encoders, S1 registers, parametrised adder tree, S2 registers, accumulator/saturation stage.
// TESTING (bench default DATA_W=8, ACC_W=24, SAT=1 unless stated)
//  1. (-128)*(-128), acc_i=0, en_i=1 -> valid_o pulses exactly 3 cycles later, res_o=16384, ovf_o=0.
//  2. Back-to-back (3,4,acc0),(-5,6,acc1),(7,-8,acc1) -> res_o 12, -18, -74 on 3 consecutive cycles.
//  3. Test 2 with en_i=0 for 2 cycles after the 2nd input -> same 3 results, each valid_o once, res_o held during stall.
//  4. ACC_W=18, SAT=1: 9x (-128*-128) with acc_i=0 then acc_i=1 x8 -> res_o saturates at 131071, ovf_o=1.
//     Next acc_i=0 load of (1,1) -> res_o=1, ovf_o=0. SAT=0: same sequence wraps to -114688, ovf_o=1.
//  5. rst_n low for 1 cycle with 2 transactions in flight -> valid_o=0, res_o=0, ovf_o=0; no stale output afterwards.
//  6. Exhaustive 65536 pairs with acc_i=0 and random bubbles -> res_o == sext(data_i*w_i) for every valid_o, in order.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth MAC: digit encoding, partial-product
// count, saturation limits and the sign-extension-prevention constant.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_P1   = 3'd1,
    BD_P2   = 3'd2,
    BD_M1   = 3'd3,
    BD_M2   = 3'd4
  } booth_digit_e;

  function automatic int pp_count(input int data_w);
    return data_w / 2;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return BD_P1;
      3'b011:         return BD_P2;
      3'b100:         return BD_M2;
      3'b101, 3'b110: return BD_M1;
      default:        return BD_ZERO;
    endcase
  endfunction

  function automatic logic [127:0] sat_max(input int acc_w);
    return (128'd1 << (acc_w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

  // Each row carries its sign as an inverted extend bit worth +2^DATA_W;
  // this constant removes that bias from every row (the "leading 1s").
  function automatic logic [127:0] ext_const(input int data_w);
    logic [127:0] c;
    c = '0;
    for (int i = 0; i < data_w / 2; i++) begin
      c = c + (128'd1 << (data_w + 2 * i));
    end
    return ~c + 128'd1;
  endfunction

endpackage

// File: rtl/booth_radix4_pp_enc.sv
// One radix-4 Booth partial-product encoder: selects 0, +-A or +-2A from a
// 3-bit multiplier window, returning the one's-complemented row plus negate bit.
module booth_radix4_pp_enc
  import booth_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic        [2:0]        i_win,
  input  logic signed [DATA_W-1:0] i_data,
  output logic        [DATA_W:0]   o_pp,
  output logic                     o_ext,
  output logic                     o_neg
);

  booth_digit_e      w_digit;
  logic [DATA_W:0]   w_mag;

  always_comb begin
    w_digit = booth_decode(i_win);
    w_mag   = '0;
    case (w_digit)
      BD_P1, BD_M1: w_mag = {i_data[DATA_W-1], i_data};
      BD_P2, BD_M2: w_mag = {i_data, 1'b0};
      default:      w_mag = '0;
    endcase
  end

  // Negation is ~x here plus o_neg added at the row LSB in the adder tree.
  assign o_neg = (w_digit == BD_M1) || (w_digit == BD_M2);
  assign o_pp  = w_mag ^ {(DATA_W + 1){o_neg}};
  assign o_ext = ~o_pp[DATA_W];

endmodule

// File: rtl/booth_radix4_mac_pipe.sv
// Three-stage signed Booth radix-4 multiply-accumulate: S1 encode, S2 adder
// tree, S3 accumulate with optional saturation and sticky overflow.
module booth_radix4_mac_pipe
  import booth_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SAT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic                     acc_i,
  output logic                     valid_o,
  output logic signed [ACC_W-1:0]  res_o,
  output logic                     ovf_o
);

  localparam int PP_N   = pp_count(DATA_W);
  localparam int PROD_W = 2 * DATA_W;
  localparam int ROWS   = PP_N + 2;
  localparam int LEAVES = 1 << $clog2(ROWS);
  localparam logic [PROD_W-1:0] EXT_CONST = PROD_W'(ext_const(DATA_W));
  localparam logic [ACC_W-1:0]  SAT_MAX   = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0]  SAT_MIN   = ACC_W'(sat_min(ACC_W));

  logic [DATA_W:0] w_win_ext;
  logic [DATA_W:0] w_pp [PP_N];
  logic            w_ext [PP_N];
  logic            w_neg [PP_N];
  logic [PP_N-1:0] w_pp_msb_unused;

  // S1 row = {extend bit, low DATA_W bits of pp}; the pp MSB is folded into ext.
  logic [DATA_W:0] r_row1 [PP_N];
  logic            r_neg1 [PP_N];
  logic            r_v1;
  logic            r_acc1;

  assign w_win_ext = {w_i, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < PP_N; gi++) begin : g_enc
      booth_radix4_pp_enc #(.DATA_W(DATA_W)) u_enc (
        .i_win  (w_win_ext[2*gi+2:2*gi]),
        .i_data (data_i),
        .o_pp   (w_pp[gi]),
        .o_ext  (w_ext[gi]),
        .o_neg  (w_neg[gi])
      );

      assign w_pp_msb_unused[gi] = w_pp[gi][DATA_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_row1[gi] <= '0;
          r_neg1[gi] <= 1'b0;
        end else if (en_i) begin
          r_row1[gi] <= {w_ext[gi], w_pp[gi][DATA_W-1:0]};
          r_neg1[gi] <= w_neg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_acc1 <= 1'b0;
    end else if (en_i) begin
      r_v1   <= valid_i;
      r_acc1 <= acc_i;
    end
  end

  // Heap-ordered binary adder tree: leaves are the shifted rows, the packed
  // negate bits and the extension constant; node 0 is the product.
  logic [PROD_W-1:0] w_node [2*LEAVES-1];

  always_comb begin
    for (int k = 0; k < 2 * LEAVES - 1; k++) begin
      w_node[k] = '0;
    end
    for (int i = 0; i < PP_N; i++) begin
      w_node[LEAVES-1+i] = PROD_W'(r_row1[i]) << (2 * i);
      w_node[LEAVES-1+PP_N][2*i] = r_neg1[i];
    end
    w_node[LEAVES+PP_N] = EXT_CONST;
    for (int k = LEAVES - 2; k >= 0; k--) begin
      w_node[k] = w_node[2*k+1] + w_node[2*k+2];
    end
  end

  logic [PROD_W-1:0] r_prod2;
  logic              r_v2;
  logic              r_acc2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod2 <= '0;
      r_v2    <= 1'b0;
      r_acc2  <= 1'b0;
    end else if (en_i) begin
      r_prod2 <= w_node[0];
      r_v2    <= r_v1;
      r_acc2  <= r_acc1;
    end
  end

  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_ovf;
  logic signed [ACC_W-1:0] w_acc_next;
  logic                    w_ovf_next;

  assign w_prod_ext = ACC_W'($signed(r_prod2));
  assign w_sum      = {res_o[ACC_W-1], res_o} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_acc_next = w_prod_ext;
    w_ovf_next = 1'b0;
    if (r_acc2) begin
      w_ovf_next = ovf_o | w_ovf;
      if (w_ovf && SAT) begin
        w_acc_next = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
      end else begin
        w_acc_next = w_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      res_o   <= '0;
      ovf_o   <= 1'b0;
    end else if (en_i) begin
      valid_o <= r_v2;
      if (r_v2) begin
        res_o <= w_acc_next;
        ovf_o <= w_ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_booth_radix4_mac_pipe.sv
// Bench for booth_radix4_mac_pipe: three instances (24-bit sat, 18-bit sat,
// 18-bit wrap) share one stimulus stream and are checked against a plain-arithmetic model.
module tb_booth_radix4_mac_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_i = 1'b1;
  logic valid_i = 1'b0;
  logic acc_i = 1'b0;
  logic signed [7:0] data_i = '0;
  logic signed [7:0] w_i = '0;

  logic v_a, v_b, v_c, o_a, o_b, o_c;
  logic signed [23:0] r_a;
  logic signed [17:0] r_b, r_c;

  always #5 clk = ~clk;

  booth_radix4_mac_pipe #(.DATA_W(8), .ACC_W(24), .SAT(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .valid_i(valid_i), .data_i(data_i),
    .w_i(w_i), .acc_i(acc_i), .valid_o(v_a), .res_o(r_a), .ovf_o(o_a));

  booth_radix4_mac_pipe #(.DATA_W(8), .ACC_W(18), .SAT(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .valid_i(valid_i), .data_i(data_i),
    .w_i(w_i), .acc_i(acc_i), .valid_o(v_b), .res_o(r_b), .ovf_o(o_b));

  booth_radix4_mac_pipe #(.DATA_W(8), .ACC_W(18), .SAT(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .valid_i(valid_i), .data_i(data_i),
    .w_i(w_i), .acc_i(acc_i), .valid_o(v_c), .res_o(r_c), .ovf_o(o_c));

  typedef struct {
    longint r0, r1, r2;
    bit     o0, o1, o2;
    longint cyc;
  } rec_t;

  int     checks = 0;
  int     errors = 0;
  bit     verbose = 1'b1;
  rec_t   exp_q[$];
  rec_t   obs_q[$];
  longint m_acc [3];
  bit     m_ovf [3];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int cfg_w(input int k);
    return (k == 0) ? 24 : 18;
  endfunction

  function automatic bit cfg_sat(input int k);
    return k != 2;
  endfunction

  // Model: exact product, then load or add, clamp or wrap into the accumulator range.
  task automatic model_push(input longint a, input longint b, input bit acc);
    rec_t   e;
    longint p, s, span, mx, mn;
    longint res [3];
    p = a * b;
    for (int k = 0; k < 3; k++) begin
      span = longint'(1) << cfg_w(k);
      mx = span / 2 - 1;
      mn = -(span / 2);
      if (!acc) begin
        s = p;
        m_ovf[k] = 1'b0;
      end else begin
        s = m_acc[k] + p;
        if (s > mx || s < mn) begin
          m_ovf[k] = 1'b1;
          if (cfg_sat(k)) begin
            s = (s > mx) ? mx : mn;
          end else begin
            s = s & (span - 1);
            if (s > mx) s = s - span;
          end
        end
      end
      m_acc[k] = s;
      res[k] = s;
    end
    e.r0 = res[0]; e.r1 = res[1]; e.r2 = res[2];
    e.o0 = m_ovf[0]; e.o1 = m_ovf[1]; e.o2 = m_ovf[2];
    e.cyc = 0;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic drive(input bit en, input bit v, input bit acc, input int a, input int b);
    @(negedge clk);
    en_i = en;
    valid_i = v;
    acc_i = acc;
    data_i = 8'(a);
    w_i = 8'(b);
    if (en && v) model_push(a, b, acc);
  endtask

  task automatic bubbles(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);
  endtask

  function automatic longint obs_val(input int idx, input int field);
    if (idx < 0 || idx >= obs_q.size()) return 64'sh7FFF_FFFF_DEAD_BEEF;
    case (field)
      0: return obs_q[idx].r0;
      1: return obs_q[idx].r1;
      2: return obs_q[idx].r2;
      3: return longint'(obs_q[idx].o0);
      4: return longint'(obs_q[idx].o1);
      5: return longint'(obs_q[idx].o2);
      default: return obs_q[idx].cyc;
    endcase
  endfunction

  // Compare process: every edge with en_i=1 and valid_o is one transaction;
  // edges with en_i=0 must leave every output unchanged.
  bit                 en_s, rst_s;
  longint             cyc = 0;
  logic signed [23:0] p_ra = '0;
  logic signed [17:0] p_rb = '0, p_rc = '0;
  logic [5:0]         p_fl = '0;
  rec_t               exp_e, got_e;

  always begin
    @(posedge clk);
    en_s = en_i;
    rst_s = rst_n;
    cyc++;
    #1;
    if (rst_s && rst_n) begin
      if (!en_s) begin
        chk("hold_res24", r_a, p_ra);
        chk("hold_res18s", r_b, p_rb);
        chk("hold_res18w", r_c, p_rc);
        chk("hold_flags", {v_a, v_b, v_c, o_a, o_b, o_c}, p_fl);
      end else if (v_a || v_b || v_c) begin
        chk("valid_agree", {v_a, v_b, v_c}, 7);
        got_e.r0 = r_a; got_e.r1 = r_b; got_e.r2 = r_c;
        got_e.o0 = o_a; got_e.o1 = o_b; got_e.o2 = o_c;
        got_e.cyc = cyc;
        obs_q.push_back(got_e);
        if (verbose)
          $display("txn cyc=%0d res24=%0d ovf24=%0d res18s=%0d ovf18s=%0d res18w=%0d ovf18w=%0d",
                   cyc, r_a, o_a, r_b, o_b, r_c, o_c);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: actual valid_o=1 at cycle %0d, required no transaction", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          chk("res24", r_a, exp_e.r0);
          chk("ovf24", o_a, longint'(exp_e.o0));
          chk("res18s", r_b, exp_e.r1);
          chk("ovf18s", o_b, longint'(exp_e.o1));
          chk("res18w", r_c, exp_e.r2);
          chk("ovf18w", o_c, longint'(exp_e.o2));
        end
      end
    end
    p_ra = r_a;
    p_rb = r_b;
    p_rc = r_c;
    p_fl = {v_a, v_b, v_c, o_a, o_b, o_c};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "timeout");
  end

  int base;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_valid", {v_a, v_b, v_c}, 0);
    chk("reset_res24", r_a, 0);
    chk("reset_res18", r_b, 0);
    chk("reset_ovf", {o_a, o_b, o_c}, 0);
    rst_n = 1'b1;

    // 1: most-negative squared, latency exactly three enabled edges
    drive(1'b1, 1'b1, 1'b0, -128, -128);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t1_valid_edge%0d", c), v_a, longint'(c == 3));
      valid_i = 1'b0;
    end
    chk("t1_res", r_a, 16384);
    chk("t1_ovf", o_a, 0);
    bubbles(2);

    // 2: back-to-back load, accumulate, accumulate
    base = obs_q.size();
    drive(1'b1, 1'b1, 1'b0, 3, 4);
    drive(1'b1, 1'b1, 1'b1, -5, 6);
    drive(1'b1, 1'b1, 1'b1, 7, -8);
    bubbles(4);
    chk("t2_res0", obs_val(base, 0), 12);
    chk("t2_res1", obs_val(base + 1, 0), -18);
    chk("t2_res2", obs_val(base + 2, 0), -74);
    chk("t2_consec1", obs_val(base + 1, 6) - obs_val(base, 6), 1);
    chk("t2_consec2", obs_val(base + 2, 6) - obs_val(base + 1, 6), 1);

    // 3: same sequence with a two-cycle stall after the second operand
    base = obs_q.size();
    drive(1'b1, 1'b1, 1'b0, 3, 4);
    drive(1'b1, 1'b1, 1'b1, -5, 6);
    drive(1'b0, 1'b1, 1'b0, 99, 99);
    drive(1'b0, 1'b1, 1'b0, 99, 99);
    drive(1'b1, 1'b1, 1'b1, 7, -8);
    bubbles(4);
    chk("t3_count", obs_q.size() - base, 3);
    chk("t3_res0", obs_val(base, 0), 12);
    chk("t3_res1", obs_val(base + 1, 0), -18);
    chk("t3_res2", obs_val(base + 2, 0), -74);

    // 4: nine 16384 products: saturate (18-bit SAT=1) vs wrap (SAT=0), then reload
    base = obs_q.size();
    drive(1'b1, 1'b1, 1'b0, -128, -128);
    repeat (8) drive(1'b1, 1'b1, 1'b1, -128, -128);
    drive(1'b1, 1'b1, 1'b0, 1, 1);
    bubbles(4);
    chk("t4_res24", obs_val(base + 8, 0), 147456);
    chk("t4_ovf24", obs_val(base + 8, 3), 0);
    chk("t4_sat_res", obs_val(base + 8, 1), 131071);
    chk("t4_sat_ovf", obs_val(base + 8, 4), 1);
    chk("t4_wrap_res", obs_val(base + 8, 2), -114688);
    chk("t4_wrap_ovf", obs_val(base + 8, 5), 1);
    chk("t4_reload_sat_res", obs_val(base + 9, 1), 1);
    chk("t4_reload_sat_ovf", obs_val(base + 9, 4), 0);
    chk("t4_reload_wrap_res", obs_val(base + 9, 2), 1);
    chk("t4_reload_wrap_ovf", obs_val(base + 9, 5), 0);

    // 5: reset with two transactions in flight
    drive(1'b1, 1'b1, 1'b0, 5, 5);
    drive(1'b1, 1'b1, 1'b1, 2, 2);
    @(negedge clk);
    rst_n = 1'b0;
    valid_i = 1'b0;
    model_reset();
    #1;
    chk("t5_valid", {v_a, v_b, v_c}, 0);
    chk("t5_res24", r_a, 0);
    chk("t5_res18", r_b, 0);
    chk("t5_ovf", {o_a, o_b, o_c}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = obs_q.size();
    bubbles(6);
    chk("t5_no_stale", obs_q.size() - base, 0);
    chk("t5_res_after", r_a, 0);

    // 6: every operand pair, loads only, with occasional bubbles and stalls
    verbose = 1'b0;
    for (int a = -128; a < 128; a++) begin
      for (int b = -128; b < 128; b++) begin
        if ($urandom_range(0, 31) == 0)
          drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);
        if ($urandom_range(0, 255) == 0)
          drive(1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, a, b);
      end
    end
    bubbles(6);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
